// File: rtl/hit_pkg.sv
// Shared types for the hit response controller: FSM state encoding and
// the counter width helper.
package hit_pkg;

    typedef enum logic [1:0] {
        ST_PLAY   = 2'd0,
        ST_INVULN = 2'd1,
        ST_OVER   = 2'd2
    } hit_state_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hit_response_ctrl_if.sv
// Bus between the collision judge / game control and the hit response controller.
interface hit_response_ctrl_if
    import hit_pkg::*;
#(
    parameter int LIVES_MAX = 7
);
    localparam int LIVES_W = cnt_w(LIVES_MAX);

    // No valid/ready here: frame_tick, restart and extra_life are single-cycle
    // pulses sampled at the clock edge, collision is a level; every output is
    // a registered level except hit_pulse, which is high for exactly one cycle.
    logic               frame_tick;
    logic               collision;
    logic               restart;
    logic               extra_life;
    logic [LIVES_W-1:0] lives;
    logic               hit_pulse;
    logic               invuln;
    logic               player_visible;
    logic               game_over;
    hit_state_e         state;

    modport master (
        output frame_tick, collision, restart, extra_life,
        input  lives, hit_pulse, invuln, player_visible, game_over, state
    );

    modport slave (
        input  frame_tick, collision, restart, extra_life,
        output lives, hit_pulse, invuln, player_visible, game_over, state
    );

endinterface

// File: rtl/hit_response_ctrl_invuln_timer.sv
// Frame countdown for the invulnerability window plus the blink divider.
// done/blink are single-cycle strobes qualified by frame_tick.
module invuln_timer
    import hit_pkg::*;
#(
    parameter int INVULN_TICKS = 120,
    parameter int BLINK_PERIOD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_clear,
    input  logic i_frame_tick,
    output logic o_done,
    output logic o_blink
);
    localparam int CW = cnt_w(INVULN_TICKS);
    localparam int BW = cnt_w(BLINK_PERIOD);

    logic [CW-1:0] r_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic          w_step;

    // Ticks only count while the window is open; a zero counter stays at zero.
    assign w_step  = i_frame_tick && (r_cnt != '0);
    assign o_done  = w_step && (r_cnt == CW'(1));
    assign o_blink = w_step && (r_blink_cnt == BW'(BLINK_PERIOD - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_blink_cnt <= '0;
        end else if (i_clear) begin
            r_cnt       <= '0;
            r_blink_cnt <= '0;
        end else if (i_load) begin
            r_cnt       <= CW'(INVULN_TICKS);
            r_blink_cnt <= '0;
        end else if (w_step) begin
            r_cnt       <= r_cnt - CW'(1);
            r_blink_cnt <= o_blink ? '0 : r_blink_cnt + BW'(1);
        end
    end

endmodule

// File: rtl/hit_response_ctrl.sv
// Hit response controller: life counter, invulnerability/blink and game-over FSM.
// Optional feature: define HIT_EXTRA_LIFE_EN to let extra_life grant lives.
module hit_response_ctrl
    import hit_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int LIVES_MAX    = 7,
    parameter int INVULN_TICKS = 120,
    parameter int BLINK_PERIOD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    hit_response_ctrl_if.slave   bus
);
    localparam int LIVES_W = cnt_w(LIVES_MAX);

    hit_state_e         r_state;
    logic [LIVES_W-1:0] r_lives;
    logic               r_hit_pulse;
    logic               r_invuln;
    logic               r_visible;
    logic               r_game_over;

    logic w_hit;
    logic w_load;
    logic w_done;
    logic w_blink;
    logic w_ext_inc;

    // restart outranks everything, so it also suppresses a hit in the same cycle.
    assign w_hit  = (r_state == ST_PLAY) && bus.collision && !bus.restart;
    assign w_load = w_hit && (r_lives > LIVES_W'(1));

`ifdef HIT_EXTRA_LIFE_EN
    assign w_ext_inc = bus.extra_life && (r_state != ST_OVER) && !w_hit;
`else
    assign w_ext_inc = 1'b0;
`endif

    invuln_timer #(
        .INVULN_TICKS (INVULN_TICKS),
        .BLINK_PERIOD (BLINK_PERIOD)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_clear      (bus.restart),
        .i_frame_tick (bus.frame_tick),
        .o_done       (w_done),
        .o_blink      (w_blink)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_PLAY;
            r_lives     <= LIVES_W'(LIVES_INIT);
            r_hit_pulse <= 1'b0;
            r_invuln    <= 1'b0;
            r_visible   <= 1'b1;
            r_game_over <= 1'b0;
        end else if (bus.restart) begin
            r_state     <= ST_PLAY;
            r_lives     <= LIVES_W'(LIVES_INIT);
            r_hit_pulse <= 1'b0;
            r_invuln    <= 1'b0;
            r_visible   <= 1'b1;
            r_game_over <= 1'b0;
        end else begin
            r_hit_pulse <= 1'b0;
            if (w_ext_inc && (r_lives < LIVES_W'(LIVES_MAX)))
                r_lives <= r_lives + LIVES_W'(1);
            case (r_state)
                ST_PLAY: begin
                    if (w_hit) begin
                        r_hit_pulse <= 1'b1;
                        if (r_lives <= LIVES_W'(1)) begin
                            r_lives     <= '0;
                            r_state     <= ST_OVER;
                            r_game_over <= 1'b1;
                            r_visible   <= 1'b0;
                        end else begin
                            r_lives  <= r_lives - LIVES_W'(1);
                            r_state  <= ST_INVULN;
                            r_invuln <= 1'b1;
                        end
                    end
                end
                ST_INVULN: begin
                    // The final tick ends the window and forces the sprite back on.
                    if (w_done) begin
                        r_state   <= ST_PLAY;
                        r_invuln  <= 1'b0;
                        r_visible <= 1'b1;
                    end else if (w_blink) begin
                        r_visible <= !r_visible;
                    end
                end
                ST_OVER: begin
                    r_lives <= '0;
                end
                default: begin
                    r_state <= ST_PLAY;
                end
            endcase
        end
    end

    assign bus.lives          = r_lives;
    assign bus.hit_pulse      = r_hit_pulse;
    assign bus.invuln         = r_invuln;
    assign bus.player_visible = r_visible;
    assign bus.game_over      = r_game_over;
    assign bus.state          = r_state;

endmodule
